// File: rtl/tbird_pkg.sv
// Shared types for the thunderbird signal controller: mode encoding and sweep width.
package tbird_pkg;

  typedef enum logic [2:0] {
    OFF    = 3'd0,
    LEFT   = 3'd1,
    RIGHT  = 3'd2,
    HAZARD = 3'd3,
    DRAIN  = 3'd4
  } mode_t;

  localparam int SWEEP_W = 8;

endpackage

// File: rtl/tbird_prescaler.sv
// Step-enable generator: one-cycle pulse every PRESCALE clocks while run is high.
module tbird_prescaler #(
  parameter int PRESCALE = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  output logic step_en
);

  localparam int CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [CNT_W-1:0] r_pcnt;
  logic             r_stepEn;
  logic             w_wrap;

  assign w_wrap = (r_pcnt == CNT_W'(PRESCALE - 1));

  // Counter is parked at zero whenever run drops so every restart begins a full period.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pcnt   <= '0;
      r_stepEn <= 1'b0;
    end else if (!run) begin
      r_pcnt   <= '0;
      r_stepEn <= 1'b0;
    end else begin
      r_stepEn <= w_wrap;
      r_pcnt   <= w_wrap ? '0 : r_pcnt + 1'b1;
    end
  end

  assign step_en = r_stepEn;

endmodule

// File: rtl/tbird_signal_ctrl.sv
// Thunderbird request arbiter and sequencer pacing. Define TBIRD_AUTOCANCEL_EN to
// enable sweep counting, MAX_SEQ auto-cancel, timeout pulse and re-arm lockout.
module tbird_signal_ctrl
  import tbird_pkg::*;
#(
  parameter int PRESCALE = 4,
  parameter int MAX_SEQ  = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       left_req,
  input  logic       right_req,
  input  logic       haz_req,
  input  logic       cancel,
  input  logic       seq_idle,
  output logic       step_en,
  output logic       seq_left,
  output logic       seq_right,
  output logic       seq_haz,
  output logic [2:0] mode,
  output logic       timeout
);

  if (PRESCALE < 2 || PRESCALE > 65535) begin : g_badPrescale
    $error("PRESCALE out of range 2..65535");
  end
  if (MAX_SEQ < 1 || MAX_SEQ > 255) begin : g_badMaxSeq
    $error("MAX_SEQ out of range 1..255");
  end

  mode_t r_mode;
  mode_t w_nextMode;
  logic  r_seqLeft, r_seqRight, r_seqHaz, r_timeout;
  logic  w_stepEn, w_run, w_timeoutEvt, w_sweepDone, w_lockout;

  // Stop the prescaler on the edge that enters OFF so it idles at zero.
  assign w_run = (r_mode != OFF) && (w_nextMode != OFF);

  tbird_prescaler #(
    .PRESCALE(PRESCALE)
  ) u_prescaler (
    .clk    (clk),
    .reset  (reset),
    .run    (w_run),
    .step_en(w_stepEn)
  );

`ifdef TBIRD_AUTOCANCEL_EN
  logic [SWEEP_W-1:0] r_sweep;
  logic               r_lockout;

  assign w_sweepDone = (r_sweep == SWEEP_W'(MAX_SEQ));
  assign w_lockout   = r_lockout;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sweep   <= '0;
      r_lockout <= 1'b0;
    end else begin
      if (w_nextMode == OFF || w_nextMode == HAZARD)
        r_sweep <= '0;
      else if (w_stepEn && seq_idle && (r_mode == LEFT || r_mode == RIGHT) && !w_sweepDone)
        r_sweep <= r_sweep + 1'b1;
      if (!left_req && !right_req)
        r_lockout <= 1'b0;
      else if (w_timeoutEvt)
        r_lockout <= 1'b1;
    end
  end
`else
  assign w_sweepDone = 1'b0;
  assign w_lockout   = 1'b0;
`endif

  // Priority inside a turn mode: hazard, then cancel/release/direction change, then sweep limit.
  always_comb begin
    w_nextMode   = OFF;
    w_timeoutEvt = 1'b0;
    case (r_mode)
      OFF: begin
        if (haz_req || (left_req && right_req)) w_nextMode = HAZARD;
        else if (left_req && !w_lockout)        w_nextMode = LEFT;
        else if (right_req && !w_lockout)       w_nextMode = RIGHT;
        else                                    w_nextMode = OFF;
      end
      LEFT: begin
        if (haz_req)                                 w_nextMode = HAZARD;
        else if (cancel || !left_req || right_req)   w_nextMode = DRAIN;
        else if (w_sweepDone) begin
          w_nextMode   = DRAIN;
          w_timeoutEvt = 1'b1;
        end else                                     w_nextMode = LEFT;
      end
      RIGHT: begin
        if (haz_req)                                 w_nextMode = HAZARD;
        else if (cancel || !right_req || left_req)   w_nextMode = DRAIN;
        else if (w_sweepDone) begin
          w_nextMode   = DRAIN;
          w_timeoutEvt = 1'b1;
        end else                                     w_nextMode = RIGHT;
      end
      HAZARD: begin
        if (!haz_req && !(left_req && right_req)) w_nextMode = DRAIN;
        else                                      w_nextMode = HAZARD;
      end
      DRAIN: begin
        if (haz_req)                    w_nextMode = HAZARD;
        else if (w_stepEn && seq_idle)  w_nextMode = OFF;
        else                            w_nextMode = DRAIN;
      end
      default: w_nextMode = OFF;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_mode     <= OFF;
      r_seqLeft  <= 1'b0;
      r_seqRight <= 1'b0;
      r_seqHaz   <= 1'b0;
      r_timeout  <= 1'b0;
    end else begin
      r_mode     <= w_nextMode;
      r_seqLeft  <= (w_nextMode == LEFT);
      r_seqRight <= (w_nextMode == RIGHT);
      r_seqHaz   <= (w_nextMode == HAZARD);
      r_timeout  <= w_timeoutEvt;
    end
  end

  assign step_en   = w_stepEn;
  assign seq_left  = r_seqLeft;
  assign seq_right = r_seqRight;
  assign seq_haz   = r_seqHaz;
  assign mode      = r_mode;
  assign timeout   = r_timeout;

endmodule

// File: tb/tb_tbird_signal_ctrl.sv
// Scoreboard bench for tbird_signal_ctrl; expectations follow TBIRD_AUTOCANCEL_EN when defined.
module tb_tbird_signal_ctrl;
  import tbird_pkg::*;

  localparam int PRESCALE = 4;
  localparam int MAX_SEQ  = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       left_req = 1'b0, right_req = 1'b0, haz_req = 1'b0, cancel = 1'b0, seq_idle = 1'b0;
  logic       step_en, seq_left, seq_right, seq_haz, timeout;
  logic [2:0] mode;

  int checks = 0;
  int errors = 0;
  logic [7:0] expQ[$];
  string      nameQ[$];

  tbird_signal_ctrl #(
    .PRESCALE(PRESCALE),
    .MAX_SEQ (MAX_SEQ)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .left_req (left_req),
    .right_req(right_req),
    .haz_req  (haz_req),
    .cancel   (cancel),
    .seq_idle (seq_idle),
    .step_en  (step_en),
    .seq_left (seq_left),
    .seq_right(seq_right),
    .seq_haz  (seq_haz),
    .mode     (mode),
    .timeout  (timeout)
  );

  always #5 clk = ~clk;

  // Drive one cycle of inputs and queue what the outputs must be after the next rising edge.
  task automatic applyStimulus(input logic rst, input logic l, input logic r, input logic h,
                               input logic c, input logic idle, input mode_t m,
                               input logic st, input logic to, input string nm);
    @(negedge clk);
    reset     = rst;
    left_req  = l;
    right_req = r;
    haz_req   = h;
    cancel    = c;
    seq_idle  = idle;
    expQ.push_back({3'(m), m == LEFT, m == RIGHT, m == HAZARD, st, to});
    nameQ.push_back(nm);
  endtask

  task automatic checkOutput(input logic [7:0] e, input string nm);
    logic [7:0] a;
    a = {mode, seq_left, seq_right, seq_haz, step_en, timeout};
    checks++;
    if (a !== e) begin
      errors++;
      $display("[TB] FAIL %s: got mode=%0d lrh=%b%b%b step=%b to=%b, want mode=%0d lrh=%b%b%b step=%b to=%b",
               nm, a[7:5], a[4], a[3], a[2], a[1], a[0], e[7:5], e[4], e[3], e[2], e[1], e[0]);
    end
  endtask

  // Monitor: outputs are registered, so they are sampled shortly after each rising edge.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (expQ.size() > 0) checkOutput(expQ.pop_front(), nameQ.pop_front());
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    applyStimulus(1, 0, 0, 0, 0, 0, OFF, 0, 0, "reset0");
    applyStimulus(1, 0, 0, 0, 0, 0, OFF, 0, 0, "reset1");
    applyStimulus(0, 0, 0, 0, 0, 0, OFF, 0, 0, "idleOff");

    // Left held with an idle sequencer: steps land 4, 8 and 12 cycles after entering LEFT.
    for (int k = 2; k <= 15; k++)
      applyStimulus(0, 1, 0, 0, 0, 1, LEFT, (k > 2) && (k % 4 == 2), 0, "leftSweep");

`ifdef TBIRD_AUTOCANCEL_EN
    applyStimulus(0, 1, 0, 0, 0, 1, DRAIN, 0, 1, "timeoutPulse");
    applyStimulus(0, 1, 0, 0, 0, 1, DRAIN, 0, 0, "timeoutSingle");
    applyStimulus(0, 1, 0, 0, 0, 1, DRAIN, 1, 0, "drainStep");
    applyStimulus(0, 1, 0, 0, 0, 1, OFF,   0, 0, "drainToOff");
    applyStimulus(0, 1, 0, 0, 0, 1, OFF,   0, 0, "lockoutHold0");
    applyStimulus(0, 1, 0, 0, 0, 1, OFF,   0, 0, "lockoutHold1");
    applyStimulus(0, 0, 0, 0, 0, 1, OFF,   0, 0, "lockoutClear");
    applyStimulus(0, 1, 0, 0, 0, 1, LEFT,  0, 0, "leftAfterClear");
    applyStimulus(0, 0, 0, 0, 0, 1, DRAIN, 0, 0, "releaseDrain");
    applyStimulus(0, 0, 0, 0, 0, 1, DRAIN, 0, 0, "releaseDrain1");
    applyStimulus(0, 0, 0, 0, 0, 1, DRAIN, 0, 0, "releaseDrain2");
    applyStimulus(0, 0, 0, 0, 0, 1, DRAIN, 1, 0, "releaseDrainStep");
    applyStimulus(0, 0, 0, 0, 0, 1, OFF,   0, 0, "releaseOff");
`else
    for (int k = 16; k <= 21; k++)
      applyStimulus(0, 1, 0, 0, 0, 1, LEFT, (k == 18), 0, "leftNoAutoCancel");
    applyStimulus(0, 0, 0, 0, 0, 1, DRAIN, 1, 0, "releaseDrain");
    applyStimulus(0, 1, 0, 0, 0, 1, OFF,   0, 0, "drainToOff");
    applyStimulus(0, 0, 0, 0, 0, 1, OFF,   0, 0, "offQuiet");
`endif

    // Right, then hazard overrides; drain waits for an idle step.
    applyStimulus(0, 0, 1, 0, 0, 0, RIGHT,  0, 0, "rightEnter");
    applyStimulus(0, 0, 1, 1, 0, 0, HAZARD, 0, 0, "rightToHaz");
    applyStimulus(0, 0, 0, 1, 0, 0, HAZARD, 0, 0, "hazHold");
    applyStimulus(0, 0, 0, 0, 0, 0, DRAIN,  0, 0, "hazRelease");
    applyStimulus(0, 0, 0, 0, 0, 0, DRAIN,  1, 0, "drainStepBusy");
    applyStimulus(0, 0, 0, 0, 0, 0, DRAIN,  0, 0, "drainBusyHold");
    applyStimulus(0, 0, 0, 0, 0, 0, DRAIN,  0, 0, "drainBusyHold1");
    applyStimulus(0, 0, 0, 0, 0, 0, DRAIN,  0, 0, "drainBusyHold2");
    applyStimulus(0, 0, 0, 0, 0, 0, DRAIN,  1, 0, "drainStep2");
    applyStimulus(0, 0, 0, 0, 0, 1, OFF,    0, 0, "drainIdleOff");

    // Both directions together act as hazard.
    applyStimulus(0, 1, 1, 0, 0, 0, HAZARD, 0, 0, "bothToHaz");
    applyStimulus(0, 1, 1, 0, 0, 0, HAZARD, 0, 0, "bothHold");
    applyStimulus(0, 0, 0, 0, 0, 1, DRAIN,  0, 0, "bothRelease");
    applyStimulus(0, 0, 0, 0, 0, 1, DRAIN,  0, 0, "bothDrain");
    applyStimulus(0, 0, 0, 0, 0, 1, DRAIN,  1, 0, "bothDrainStep");
    applyStimulus(0, 0, 0, 0, 0, 1, OFF,    0, 0, "bothOff");

    // Cancel and hazard together: hazard wins; then reset in the middle of DRAIN.
    applyStimulus(0, 1, 0, 0, 0, 0, LEFT,   0, 0, "leftEnter");
    applyStimulus(0, 1, 0, 1, 1, 0, HAZARD, 0, 0, "cancelVsHaz");
    applyStimulus(0, 0, 0, 0, 0, 0, DRAIN,  0, 0, "hazToDrain");
    applyStimulus(1, 0, 0, 0, 0, 0, OFF,    0, 0, "resetMidDrain");
    applyStimulus(0, 0, 0, 0, 0, 0, OFF,    0, 0, "postReset");
    applyStimulus(0, 1, 0, 0, 0, 0, LEFT,   0, 0, "leftAgain");
    for (int k = 0; k < 3; k++)
      applyStimulus(0, 1, 0, 0, 0, 0, LEFT, 0, 0, "leftWaitStep");
    applyStimulus(0, 1, 0, 0, 0, 0, LEFT,   1, 0, "firstStepAfterReset");
    applyStimulus(0, 1, 0, 0, 1, 0, DRAIN,  0, 0, "cancelDrain");
    applyStimulus(0, 0, 0, 0, 0, 0, DRAIN,  0, 0, "cancelDrain1");
    applyStimulus(0, 0, 0, 0, 0, 0, DRAIN,  0, 0, "cancelDrain2");
    applyStimulus(0, 0, 0, 0, 0, 0, DRAIN,  1, 0, "cancelDrainStep");
    applyStimulus(0, 0, 0, 0, 0, 1, OFF,    0, 0, "cancelOff");

    // Direction change from LEFT drains before RIGHT can start.
    applyStimulus(0, 1, 0, 0, 0, 0, LEFT,   0, 0, "leftEnter2");
    applyStimulus(0, 1, 1, 0, 0, 0, DRAIN,  0, 0, "dirChange");
    applyStimulus(0, 0, 1, 0, 0, 0, DRAIN,  0, 0, "dirDrain1");
    applyStimulus(0, 0, 1, 0, 0, 0, DRAIN,  0, 0, "dirDrain2");
    applyStimulus(0, 0, 1, 0, 0, 0, DRAIN,  1, 0, "dirDrainStep");
    applyStimulus(0, 0, 1, 0, 0, 1, OFF,    0, 0, "dirOff");
    applyStimulus(0, 0, 1, 0, 0, 0, RIGHT,  0, 0, "rightFromOff");
    applyStimulus(0, 0, 0, 0, 0, 0, DRAIN,  0, 0, "rightRelease");
    applyStimulus(0, 0, 0, 0, 0, 0, DRAIN,  0, 0, "rightDrain1");
    applyStimulus(0, 0, 0, 0, 0, 0, DRAIN,  0, 0, "rightDrain2");
    applyStimulus(0, 0, 0, 0, 0, 0, DRAIN,  1, 0, "rightDrainStep");
    applyStimulus(0, 0, 0, 0, 0, 1, OFF,    0, 0, "rightOff");

    repeat (2) @(negedge clk);
    if (expQ.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL drainQueue: %0d entries left, want 0", expQ.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
